// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, exception codes, mask bit positions
// and the Cause read-back layout.
package cp0_pkg;

   localparam logic [4:0] CP0_STATUS = 5'd12;
   localparam logic [4:0] CP0_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_EPC    = 5'd14;

   typedef enum logic [1:0] {
      EXC_INT    = 2'b00,
      EXC_SYS    = 2'b01,
      EXC_UNIMPL = 2'b10,
      EXC_OVF    = 2'b11
   } exc_code_e;

   localparam int MASK_INT    = 0;
   localparam int MASK_SYS    = 1;
   localparam int MASK_UNIMPL = 2;
   localparam int MASK_OVF    = 3;

   localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0040;

   // Cause as software sees it: live pending at bit 8, ExcCode at [3:2]
   function automatic logic [31:0] cause_word(input logic pend, input exc_code_e code);
      return {23'd0, pend, 4'd0, code, 2'b00};
   endfunction

endpackage

// File: rtl/cp0_intr_sync.sv
// External interrupt front end: multi-flop synchroniser, rising-edge detect and a
// pending flag that holds until the controller takes the interrupt.
module cp0_intr_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic Clk,
   input  logic Rst,
   input  logic Intr,
   input  logic Clear,
   output logic Pending
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;
   logic                   pending_r;
   logic                   rise_s;

   // synchroniser chain plus one flop of history for edge detection
   always_ff @(posedge Clk) begin
      if (Rst) begin
         sync_r <= {SYNC_STAGES{1'b0}};
         prev_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], Intr};
         prev_r <= sync_r[SYNC_STAGES-1];
      end
   end

   assign rise_s = sync_r[SYNC_STAGES-1] & ~prev_r;

   // clearing wins over a coincident edge, so that edge is dropped
   always_ff @(posedge Clk) begin
      if (Rst) begin
         pending_r <= 1'b0;
      end else if (Clear) begin
         pending_r <= 1'b0;
      end else if (rise_s) begin
         pending_r <= 1'b1;
      end
   end

   assign Pending = pending_r;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: per-cycle trap decision, next-PC select and
// the Status/Cause/EPC registers with a three-level mask stack in Status.
module cp0_exc_ctrl
   import cp0_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [31:0] Pc,
   input  logic [31:0] NextPc,
   input  logic        Mtc0,
   input  logic        Mfc0,
   input  logic        Eret,
   input  logic        Syscall,
   input  logic        Unimpl,
   input  logic        Ovf,
   input  logic [4:0]  Rd,
   input  logic [31:0] WData,
   input  logic        Intr,
   output logic [31:0] RData,
   output logic [31:0] PcOut,
   output logic        ExcTaken,
   output logic        Cancel,
   output logic        IntAck
);

   logic [11:0] status_r;
   exc_code_e   cause_code_r;
   logic [31:0] epc_r;

   logic        pending_s;
   logic        trap_s;
   logic        sync_exc_s;
   exc_code_e   code_s;
   logic        int_ack_s;
   logic [31:0] rdata_s;
   logic [31:0] pc_out_s;

   cp0_intr_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_intr_sync (
      .Clk    (Clk),
      .Rst    (Rst),
      .Intr   (Intr),
      .Clear  (int_ack_s),
      .Pending(pending_s)
   );

   // trap priority; an eret defers the interrupt until the mask is restored
   always_comb begin
      trap_s     = 1'b0;
      sync_exc_s = 1'b0;
      code_s     = EXC_INT;
      if (Ovf && status_r[MASK_OVF]) begin
         trap_s     = 1'b1;
         sync_exc_s = 1'b1;
         code_s     = EXC_OVF;
      end else if (Unimpl && status_r[MASK_UNIMPL]) begin
         trap_s     = 1'b1;
         sync_exc_s = 1'b1;
         code_s     = EXC_UNIMPL;
      end else if (Syscall && status_r[MASK_SYS]) begin
         trap_s     = 1'b1;
         sync_exc_s = 1'b1;
         code_s     = EXC_SYS;
      end else if (pending_s && status_r[MASK_INT] && !Eret) begin
         trap_s     = 1'b1;
         sync_exc_s = 1'b0;
         code_s     = EXC_INT;
      end else begin
         trap_s     = 1'b0;
         sync_exc_s = 1'b0;
         code_s     = EXC_INT;
      end
   end

   assign int_ack_s = trap_s & ~sync_exc_s;

   // next-PC select and mfc0 read mux (pre-update register values)
   always_comb begin
      pc_out_s = NextPc;
      rdata_s  = 32'd0;
      if (trap_s) begin
         pc_out_s = EXC_VECTOR;
      end else if (Eret) begin
         pc_out_s = epc_r;
      end else begin
         pc_out_s = NextPc;
      end
      if (Mfc0) begin
         case (Rd)
            CP0_STATUS: rdata_s = {20'd0, status_r};
            CP0_CAUSE:  rdata_s = cause_word(pending_s, cause_code_r);
            CP0_EPC:    rdata_s = epc_r;
            default:    rdata_s = 32'd0;
         endcase
      end else begin
         rdata_s = 32'd0;
      end
   end

   // CP0 register file; a trap overrides both eret and mtc0 in the same cycle
   always_ff @(posedge Clk) begin
      if (Rst) begin
         status_r     <= 12'd0;
         cause_code_r <= EXC_INT;
         epc_r        <= 32'd0;
      end else if (trap_s) begin
         status_r     <= {status_r[7:0], 4'b0000};
         cause_code_r <= code_s;
         epc_r        <= sync_exc_s ? Pc : NextPc;
      end else if (Eret) begin
         status_r <= {4'b0000, status_r[11:4]};
      end else if (Mtc0) begin
         case (Rd)
            CP0_STATUS: status_r <= WData[11:0];
            CP0_EPC:    epc_r    <= WData;
            default:    ;
         endcase
      end
   end

   assign RData    = rdata_s;
   assign PcOut    = pc_out_s;
   assign ExcTaken = trap_s;
   assign Cancel   = trap_s & sync_exc_s;
   assign IntAck   = int_ack_s;

endmodule
